// File: rtl/decode_control_stage_if.sv
// IF/ID -> ID/EX bus for the decode/control stage. The stage is the slave:
// it consumes the IF/ID side and drives the ID/EX register and stall line.
interface decode_control_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             ifIdValid;
  logic [31:0]      ifIdInstruction;
  logic [XLEN-1:0]  ifIdPc;
  logic             flush;
  logic             holdIn;
  logic             stallRequest;
  logic             idExValid;
  logic [XLEN-1:0]  idExPc;
  logic [4:0]       idExRs1, idExRs2, idExRd;
  logic [2:0]       idExFunct3;
  logic             pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable;
  logic             pcAdderSrc, writeBackFromAluOrMemory;
  logic [1:0]       aluSrc1, aluSrc2;
  logic [3:0]       aluOperation;
  logic             illegalInstruction;
  logic [CNT_W-1:0] bubbleCount;

  modport master (
    output ifIdValid, ifIdInstruction, ifIdPc, flush, holdIn,
    input  stallRequest, idExValid, idExPc, idExRs1, idExRs2, idExRd, idExFunct3,
           pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable,
           pcAdderSrc, writeBackFromAluOrMemory, aluSrc1, aluSrc2, aluOperation,
           illegalInstruction, bubbleCount
  );

  modport slave (
    input  ifIdValid, ifIdInstruction, ifIdPc, flush, holdIn,
    output stallRequest, idExValid, idExPc, idExRs1, idExRs2, idExRd, idExFunct3,
           pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable,
           pcAdderSrc, writeBackFromAluOrMemory, aluSrc1, aluSrc2, aluOperation,
           illegalInstruction, bubbleCount
  );
endinterface

// File: rtl/decode_control_stage.sv
// Decode/control stage: decodes the IF/ID instruction and latches control plus
// operand fields into the ID/EX register. Handles load-use bubbles, flush,
// downstream hold, illegal opcodes, optional M-extension and a bubble counter.
module decode_control_stage #(
  parameter int XLEN        = 32,
  parameter int ENABLE_MEXT = 1,
  parameter int CNT_W       = 16
) (
  input  logic clock,
  input  logic reset,
  decode_control_stage_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic            pcUpdate, memRd, memWr, regWr, pcAdderSrc, wbMem;
    logic [1:0]      aluSrc1, aluSrc2;
    logic [3:0]      aluOp;
    logic            illegal;
  } idex_t;

  idex_t            idex_q, idex_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs1Used, rs2Used, loadUse;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  assign opcode = bus.ifIdInstruction[6:0];
  assign rd     = bus.ifIdInstruction[11:7];
  assign rs1    = bus.ifIdInstruction[19:15];
  assign rs2    = bus.ifIdInstruction[24:20];
  assign funct7 = bus.ifIdInstruction[31:25];

  // Per-class control decode; a non-valid IF/ID slot decodes to a bubble.
  always_comb begin
    dec     = '0;
    rs1Used = 1'b0;
    rs2Used = 1'b0;
    case (opcode)
      OP_R: begin
        rs1Used = 1'b1;
        rs2Used = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (ENABLE_MEXT != 0) begin
            dec.regWr = 1'b1;
            dec.aluOp = 4'd8;
          end else begin
            dec.illegal = 1'b1;
          end
        end else begin
          dec.regWr = 1'b1;
          dec.aluOp = 4'd2;
        end
      end
      OP_I: begin
        rs1Used = 1'b1;
        dec.regWr = 1'b1; dec.aluSrc2 = 2'b01; dec.aluOp = 4'd3;
      end
      OP_LOAD: begin
        rs1Used = 1'b1;
        dec.memRd = 1'b1; dec.regWr = 1'b1; dec.wbMem = 1'b1;
        dec.aluSrc2 = 2'b01; dec.aluOp = 4'd0;
      end
      OP_S: begin
        rs1Used = 1'b1;
        rs2Used = 1'b1;
        dec.memWr = 1'b1; dec.aluSrc2 = 2'b01; dec.aluOp = 4'd0;
      end
      OP_B: begin
        rs1Used = 1'b1;
        rs2Used = 1'b1;
        dec.pcUpdate = 1'b1; dec.aluOp = 4'd1;
      end
      OP_JAL: begin
        dec.pcUpdate = 1'b1; dec.regWr = 1'b1;
        dec.aluSrc1 = 2'b01; dec.aluSrc2 = 2'b10; dec.aluOp = 4'd4;
      end
      OP_JALR: begin
        rs1Used = 1'b1;
        dec.pcUpdate = 1'b1; dec.pcAdderSrc = 1'b1; dec.regWr = 1'b1;
        dec.aluSrc1 = 2'b01; dec.aluSrc2 = 2'b10; dec.aluOp = 4'd5;
      end
      OP_LUI: begin
        dec.regWr = 1'b1; dec.aluSrc1 = 2'b10; dec.aluSrc2 = 2'b01; dec.aluOp = 4'd6;
      end
      OP_AUIPC: begin
        dec.regWr = 1'b1; dec.aluSrc1 = 2'b01; dec.aluSrc2 = 2'b01; dec.aluOp = 4'd7;
      end
      default: dec.illegal = 1'b1;
    endcase
    // x0 is never a real destination.
    if (rd == 5'd0) dec.regWr = 1'b0;
    dec.valid  = 1'b1;
    dec.pc     = bus.ifIdPc;
    dec.rs1    = rs1;
    dec.rs2    = rs2;
    dec.rd     = rd;
    dec.funct3 = bus.ifIdInstruction[14:12];
    if (!bus.ifIdValid) dec = '0;
  end

  // Load in ID/EX whose rd feeds a source actually read by the IF/ID instruction.
  assign loadUse = idex_q.valid & idex_q.memRd & (idex_q.rd != 5'd0) & bus.ifIdValid &
                   ((rs1Used & (rs1 == idex_q.rd)) | (rs2Used & (rs2 == idex_q.rd)));

  assign bus.stallRequest = bus.holdIn | (loadUse & ~bus.flush);

  // Next-state selection: flush > hold > load-use bubble > normal load.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      idex_d = '0;
    end else if (bus.holdIn) begin
      idex_d = idex_q;
    end else if (loadUse) begin
      idex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      idex_d = dec;
    end
  end

  // ID/EX pipeline register and bubble counter with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.idExValid                = idex_q.valid;
  assign bus.idExPc                   = idex_q.pc;
  assign bus.idExRs1                  = idex_q.rs1;
  assign bus.idExRs2                  = idex_q.rs2;
  assign bus.idExRd                   = idex_q.rd;
  assign bus.idExFunct3               = idex_q.funct3;
  assign bus.pcUpdate                 = idex_q.pcUpdate;
  assign bus.memoryReadEnable         = idex_q.memRd;
  assign bus.memoryWriteEnable        = idex_q.memWr;
  assign bus.registerWriteEnable      = idex_q.regWr;
  assign bus.pcAdderSrc               = idex_q.pcAdderSrc;
  assign bus.writeBackFromAluOrMemory = idex_q.wbMem;
  assign bus.aluSrc1                  = idex_q.aluSrc1;
  assign bus.aluSrc2                  = idex_q.aluSrc2;
  assign bus.aluOperation             = idex_q.aluOp;
  assign bus.illegalInstruction       = idex_q.illegal;
  assign bus.bubbleCount              = cnt_q;
endmodule

// File: tb/tb_decode_control_stage.sv
// Bench for decode_control_stage: two instances (M-ext on / 16-bit counter,
// M-ext off / 2-bit counter) share one stimulus stream and are compared every
// cycle against a table-driven reference model.
module tb_decode_control_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        vld, fl, hd;
  logic [31:0] ins, pc;

  decode_control_stage_if #(.XLEN(32), .CNT_W(16)) bus0 ();
  decode_control_stage_if #(.XLEN(32), .CNT_W(2))  bus1 ();

  assign bus0.ifIdValid = vld; assign bus0.ifIdInstruction = ins; assign bus0.ifIdPc = pc;
  assign bus0.flush = fl;      assign bus0.holdIn = hd;
  assign bus1.ifIdValid = vld; assign bus1.ifIdInstruction = ins; assign bus1.ifIdPc = pc;
  assign bus1.flush = fl;      assign bus1.holdIn = hd;

  decode_control_stage #(.XLEN(32), .ENABLE_MEXT(1), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  decode_control_stage #(.XLEN(32), .ENABLE_MEXT(0), .CNT_W(2)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  // ctl = {pcUpdate, memRd, memWr, regWr, pcAdderSrc, wbMem, aluSrc1[2], aluSrc2[2], aluOp[4]}
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [13:0] ctl;
    logic        ill;
  } st_t;

  st_t obs0, obs1;
  assign obs0 = {bus0.idExValid, bus0.idExPc, bus0.idExRs1, bus0.idExRs2, bus0.idExRd, bus0.idExFunct3,
                 bus0.pcUpdate, bus0.memoryReadEnable, bus0.memoryWriteEnable, bus0.registerWriteEnable,
                 bus0.pcAdderSrc, bus0.writeBackFromAluOrMemory, bus0.aluSrc1, bus0.aluSrc2,
                 bus0.aluOperation, bus0.illegalInstruction};
  assign obs1 = {bus1.idExValid, bus1.idExPc, bus1.idExRs1, bus1.idExRs2, bus1.idExRd, bus1.idExFunct3,
                 bus1.pcUpdate, bus1.memoryReadEnable, bus1.memoryWriteEnable, bus1.registerWriteEnable,
                 bus1.pcAdderSrc, bus1.writeBackFromAluOrMemory, bus1.aluSrc1, bus1.aluSrc2,
                 bus1.aluOperation, bus1.illegalInstruction};

  int   errors = 0, checks = 0;
  st_t  m [2];
  int   c [2];
  int   cmax [2] = '{65535, 3};
  bit   mext [2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic st_t dec_ref(logic v, logic [31:0] w, logic [31:0] p, bit me);
    st_t s = '0;
    logic [13:0] k = '0;
    logic il = 1'b0;
    if (!v) return s;
    case (w[6:0])
      7'b0110011: begin
        if (w[31:25] == 7'b0000001) begin
          if (me) k = 14'b0_0_0_1_0_0_00_00_1000; else il = 1'b1;
        end else k = 14'b0_0_0_1_0_0_00_00_0010;
      end
      7'b0010011: k = 14'b0_0_0_1_0_0_00_01_0011;
      7'b0000011: k = 14'b0_1_0_1_0_1_00_01_0000;
      7'b0100011: k = 14'b0_0_1_0_0_0_00_01_0000;
      7'b1100011: k = 14'b1_0_0_0_0_0_00_00_0001;
      7'b1101111: k = 14'b1_0_0_1_0_0_01_10_0100;
      7'b1100111: k = 14'b1_0_0_1_1_0_01_10_0101;
      7'b0110111: k = 14'b0_0_0_1_0_0_10_01_0110;
      7'b0010111: k = 14'b0_0_0_1_0_0_01_01_0111;
      default:    il = 1'b1;
    endcase
    if (w[11:7] == 5'd0) k[10] = 1'b0;
    s.v = 1'b1; s.pc = p; s.rs1 = w[19:15]; s.rs2 = w[24:20]; s.rd = w[11:7];
    s.f3 = w[14:12]; s.ctl = k; s.ill = il;
    return s;
  endfunction

  function automatic bit lu_ref(st_t s, logic v, logic [31:0] w);
    logic [6:0] op = w[6:0];
    bit u1 = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111});
    bit u2 = (op inside {7'b0110011, 7'b0100011, 7'b1100011});
    if (!(s.v && s.ctl[12] && s.rd != 5'd0 && v)) return 1'b0;
    return (u1 && w[19:15] == s.rd) || (u2 && w[24:20] == s.rd);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit lu = lu_ref(m[k], vld, ins);
      if (reset) begin m[k] = '0; c[k] = 0; end
      else if (fl) m[k] = '0;
      else if (hd) m[k] = m[k];
      else if (lu) begin m[k] = '0; if (c[k] < cmax[k]) c[k]++; end
      else m[k] = dec_ref(vld, ins, pc, mext[k]);
    end
  endtask

  // Called at a negedge after inputs are set: checks stall, clocks, checks state.
  task automatic step(input int exp_stall = -1);
    logic sref;
    #1;
    sref = hd | (lu_ref(m[0], vld, ins) & ~fl);
    chk("stall0", bus0.stallRequest, sref);
    chk("stall1", bus1.stallRequest, sref);
    if (exp_stall >= 0) chk("stall_dir", bus0.stallRequest, exp_stall[0]);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("idex0", obs0, m[0]);
    chk("idex1", obs1, m[1]);
    chk("cnt0", bus0.bubbleCount, c[0]);
    chk("cnt1", bus1.bubbleCount, c[1]);
  endtask

  task automatic put(input logic r, input logic v, input logic [31:0] w, input logic f, input logic h);
    reset = r; vld = v; ins = w; fl = f; hd = h; pc = $urandom;
  endtask

  function automatic logic [31:0] rt(logic [6:0] f7, logic [4:0] b, logic [4:0] a, logic [4:0] d);
    return {f7, b, a, 3'b000, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] it(logic [11:0] im, logic [4:0] a, logic [2:0] f3, logic [4:0] d,
                                     logic [6:0] op);
    return {im, a, f3, d, op};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 10);
    if (sel < 9) w[6:0] = ops[sel];
    else if (sel == 9) begin w[6:0] = 7'b0110011; w[31:25] = 7'b0000001; end
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'b0110011 && sel != 9) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'b0 : 7'b0100000;
    return w;
  endfunction

  logic [31:0] LW5, ADD6, LW0, ADD0, ADDI0, MUL, BAD;
  int   sat_exp [5] = '{1, 2, 3, 3, 3};
  st_t  snap;

  initial begin
    LW5   = it(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
    ADD6  = rt(7'd0, 5'd2, 5'd5, 5'd6);
    LW0   = it(12'd4, 5'd1, 3'b010, 5'd0, 7'b0000011);
    ADD0  = rt(7'd0, 5'd0, 5'd0, 5'd6);
    ADDI0 = it(12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011);
    MUL   = rt(7'b0000001, 5'd2, 5'd5, 5'd6);
    BAD   = 32'h0000_307F;
    m[0] = '0; m[1] = '0; c[0] = 0; c[1] = 0;
    @(negedge clock);

    // Reset with random inputs: everything zero, stall follows holdIn.
    put(1'b1, 1'b0, $urandom, 1'($urandom), 1'($urandom)); step();
    put(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom)); #1;
    chk("rst_stall", bus0.stallRequest, hd); step();

    // Load-use: one bubble then the dependent add.
    put(1'b0, 1'b1, LW5, 1'b0, 1'b0); step(0);
    put(1'b0, 1'b1, ADD6, 1'b0, 1'b0); step(1);
    chk("lu_bubble", bus0.idExValid, 1'b0);
    chk("lu_cnt", bus0.bubbleCount, 16'd1);
    step(0);
    chk("lu_add", bus0.aluOperation, 4'd2);
    chk("lu_add_v", bus0.idExValid, 1'b1);

    // x0 destination: no hazard, no write enable.
    put(1'b0, 1'b1, LW0, 1'b0, 1'b0); step();
    put(1'b0, 1'b1, ADD0, 1'b0, 1'b0); step(0);
    put(1'b0, 1'b1, ADDI0, 1'b0, 1'b0); step(0);
    chk("x0_rwe", bus0.registerWriteEnable, 1'b0);

    // Flush with hold and a dependent instruction in flight.
    put(1'b0, 1'b1, LW5, 1'b0, 1'b0); step();
    put(1'b0, 1'b1, ADD6, 1'b1, 1'b1); step(1);
    chk("fl_bubble", bus0.idExValid, 1'b0);
    chk("fl_cnt", bus0.bubbleCount, 16'd1);
    put(1'b0, 1'b1, ADD6, 1'b0, 1'b0); step(0);

    // Reset during a pending hazard drops it.
    put(1'b0, 1'b1, LW5, 1'b0, 1'b0); step();
    put(1'b1, 1'b1, ADD6, 1'b0, 1'b0); step();
    put(1'b0, 1'b1, ADD6, 1'b0, 1'b0); step(0);

    // M-extension and illegal opcodes.
    put(1'b0, 1'b1, MUL, 1'b0, 1'b0); step();
    chk("mext_op", bus0.aluOperation, 4'd8);
    chk("nomext_ill", bus1.illegalInstruction, 1'b1);
    chk("nomext_en", {bus1.registerWriteEnable, bus1.memoryReadEnable, bus1.memoryWriteEnable,
                      bus1.pcUpdate}, 4'b0);
    put(1'b0, 1'b1, BAD, 1'b0, 1'b0); step();
    chk("bad_ill", bus0.illegalInstruction, 1'b1);

    // Counter saturation on the 2-bit instance.
    put(1'b1, 1'b0, 32'd0, 1'b0, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      put(1'b0, 1'b1, LW5, 1'b0, 1'b0); step();
      put(1'b0, 1'b1, ADD6, 1'b0, 1'b0); step(1);
      chk("sat", bus1.bubbleCount, sat_exp[i][1:0]);
    end

    // Hold freezes the register for three cycles.
    put(1'b0, 1'b1, LW5, 1'b0, 1'b0); step();
    snap = m[0];
    for (int i = 0; i < 3; i++) begin
      put(1'b0, 1'($urandom), rand_ins(), 1'b0, 1'b1); step(1);
      chk("hold", obs0, snap);
    end

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      put($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, rand_ins(),
          $urandom_range(0, 11) == 0, $urandom_range(0, 6) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
